// File: rtl/ban_reg_ctx.sv
// Parametrised working register bank with a shadow (context) bank and a
// sequential save/restore engine that copies one register per clock.
module ban_reg_ctx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W,
  input  logic [ADDR_W-1:0] sel_w,
  input  logic [DATA_W-1:0] DW,
  input  logic [ADDR_W-1:0] sel_x,
  input  logic [ADDR_W-1:0] sel_y,
  output logic [DATA_W-1:0] Rx,
  output logic [DATA_W-1:0] Ry,
  input  logic              save,
  input  logic              restore,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  logic wr_en_c;
  logic wr_keep_c;
  logic rs_keep_c;
  logic r0_zero_c;

  assign r0_zero_c = (ZERO_R0 != 0);
  assign wr_en_c   = W && !busy_q;
  assign wr_keep_c = wr_en_c && !(r0_zero_c && (sel_w == '0));
  assign rs_keep_c = (state_q == RESTORE) && !(r0_zero_c && (idx_q == '0));

  // State, index and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Copy engine: save has priority over restore; requests ignored while busy
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (save) begin
          state_d = SAVE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else if (restore) begin
          state_d = RESTORE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SAVE, RESTORE: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Working and shadow arrays; host writes and restore copies never overlap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (wr_keep_c) begin
        regs[sel_w] <= DW;
      end
      if (rs_keep_c) begin
        regs[idx_q] <= shadow[idx_q];
      end
      if (state_q == SAVE) begin
        shadow[idx_q] <= regs[idx_q];
      end
    end
  end

  // Asynchronous read ports with optional bypass and hardwired-zero R0
  always_comb begin
    Rx = regs[sel_x];
    if ((BYPASS != 0) && wr_en_c && (sel_w == sel_x)) begin
      Rx = DW;
    end
    if (r0_zero_c && (sel_x == '0)) begin
      Rx = '0;
    end
  end

  always_comb begin
    Ry = regs[sel_y];
    if ((BYPASS != 0) && wr_en_c && (sel_w == sel_y)) begin
      Ry = DW;
    end
    if (r0_zero_c && (sel_y == '0)) begin
      Ry = '0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/ban_reg_ctx.md
Name: ban_reg_ctx

Overview:
- Parametrised successor to the micro's 8x8 register bank.
- Provides DEPTH = 2**ADDR_W working registers of DATA_W bits, with two asynchronous read ports, one synchronous write port, optional write-to-read bypass and optional hardwired-zero R0.
- Adds a shadow (context) bank. A sequential engine copies working->shadow (save) or shadow->working (restore), one register per clock, so the control unit can switch context on interrupt entry and exit.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W.
- BYPASS, 1, 1 = a read of the address being written this cycle returns DW combinationally.
- ZERO_R0, 0, 1 = register 0 always reads 0; writes and restores to it are discarded.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- W  in  1  write enable.
- sel_w  in  ADDR_W  write address.
- DW  in  DATA_W  write data.
- sel_x  in  ADDR_W  read address, port X.
- sel_y  in  ADDR_W  read address, port Y.
- Rx  out  DATA_W  read data, port X.
- Ry  out  DATA_W  read data, port Y.
- save  in  1  request copy working->shadow (sampled in IDLE).
- restore  in  1  request copy shadow->working (sampled in IDLE).
- busy  out  1  copy engine active.
- done  out  1  one-cycle pulse, copy finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - All working and shadow registers = 0.
  - State = IDLE, index = 0, busy = 0, done = 0.
  - A reset mid-copy aborts the copy immediately; no done pulse is produced.
- Reads:
  - Combinational: Rx = reg[sel_x], Ry = reg[sel_y].
  - If BYPASS=1 and W=1 and busy=0 and sel_w==sel_x, then Rx = DW. The same rule applies to Ry with sel_y.
  - If ZERO_R0=1, reading address 0 returns 0, with or without bypass.
- Write:
  - At the rising edge, if W=1 and busy=0, reg[sel_w] <= DW.
  - W is ignored while busy=1. Writes to R0 are discarded when ZERO_R0=1.
- State machine: IDLE, SAVE, RESTORE.
  - IDLE, save=1 at edge k: go to SAVE, index=0, busy=1 after edge k. If save=1 and restore=1 together, save wins.
  - IDLE, restore=1 (save=0): go to RESTORE, index=0, busy=1.
  - SAVE, each edge: shadow[index] <= reg[index], then index++.
  - RESTORE, each edge: reg[index] <= shadow[index], then index++. R0 is skipped if ZERO_R0=1.
  - At the copy edge with index==DEPTH-1: go to IDLE, index=0, busy=0, done=1 for exactly one cycle.
- Timing:
  - A request at edge k keeps busy high over edges k+1..k+DEPTH. done is high in the cycle after edge k+DEPTH.
  - The next request is accepted at edge k+DEPTH+1 at the earliest.
  - save/restore are ignored while busy; they are not queued.
  - A write at edge k (busy still 0 at that edge) lands before the save reaches that register, so the new value is saved.
- Reads during busy return the live working array. During RESTORE the array is partially updated until done.
- Widths: index is ADDR_W bits; its wrap from DEPTH-1 to 0 coincides with the return to IDLE.

Test Plan (DATA_W=8, ADDR_W=3, BYPASS=1, ZERO_R0=0 unless stated):
1. Reset, then write 0x0A..0x11 to R0..R7 on consecutive cycles. Then sel_x=1, sel_y=7 -> Rx=0x0B, Ry=0x11. Before any write, all reads return 0x00.
2. Bypass: W=1, sel_w=3, DW=0x5A, sel_x=3 in the same cycle -> Rx=0x5A before the edge, and reg3=0x5A after it. With BYPASS=0 -> Rx=0x0D before the edge.
3. Save/restore:
   - Pulse save -> busy=1 for 8 cycles, done=1 for 1 cycle.
   - Overwrite R0..R7 with 0xFF. A W=1 write issued while busy is ignored; check the register is unchanged.
   - Pulse restore -> after done, R0..R7 = 0x0A..0x11.
4. Simultaneous save=1 and restore=1 in IDLE -> SAVE runs (shadow updated, working registers unchanged). A restore pulse raised while busy is ignored: busy drops after 8 cycles with no second copy.
5. Reset mid-operation: assert rst=0 during cycle 4 of a RESTORE -> busy=0, done=0, all registers 0 immediately. After rst=1, the first read returns 0x00.
6. ZERO_R0=1: write 0x33 to R0, restore a shadow whose R0 = 0x77 -> Rx(sel_x=0)=0x00 throughout, including when a same-cycle bypass write targets R0.
